// File: rtl/bram_read_client_pkg.sv
// Shared definitions for BRAM read-port clients.
// Read latency, width helpers and common field widths.
package bram_read_client_pkg;

    // BRAM returns DOUT exactly this many cycles after RD_EN
    localparam int unsigned BRAM_RD_LATENCY = 1;

    // Default field widths common to BRAM clients
    localparam int unsigned BRAM_ADDR_W_DFLT = 1;
    localparam int unsigned BRAM_DATA_W_DFLT = 1;

    // Smallest r with 2**r >= v
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Pointer width for a circular buffer, never zero
    function automatic int unsigned ptr_width(input int unsigned n);
        int unsigned r;
        r = clog2(n);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bram_read_client_resp_fifo.sv
// Response FIFO: circular buffer, any depth >= 2.
// Pushed data is visible only from the next cycle.
module bram_read_client_resp_fifo
    import bram_read_client_pkg::*;
#(
    parameter int unsigned data_width = 1,
    parameter int unsigned depth      = 4,
    localparam int unsigned PW = ptr_width(depth),
    localparam int unsigned CW = clog2(depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [data_width-1:0] data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [data_width-1:0] data_o,
    output logic [CW-1:0]         count_o
);

    logic [data_width-1:0] mem_q [depth];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i & (count_q != '0);
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wrap_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage, written only on push
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Credit logic upstream must make a push into a full FIFO impossible
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !do_pop && count_q == CW'(depth))
    );

endmodule

// File: rtl/bram_read_client.sv
// Initiator for one BRAM read port with credit-based
// response buffering, so BRAM data is never dropped.
module bram_read_client
    import bram_read_client_pkg::*;
#(
    parameter int unsigned addr_width = BRAM_ADDR_W_DFLT,
    parameter int unsigned data_width = BRAM_DATA_W_DFLT,
    parameter int unsigned depth      = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    input  logic [addr_width-1:0] REQ_ADDR,
    output logic                  REQ_READY,
    output logic                  BRAM_RD_EN,
    output logic [addr_width-1:0] BRAM_RD_ADDR,
    input  logic [data_width-1:0] BRAM_DOUT,
    input  logic                  BRAM_DOUT_RDY,
    output logic                  RESP_VALID,
    output logic [data_width-1:0] RESP_DATA,
    input  logic                  RESP_READY,
    output logic                  ERR_SPURIOUS
);

    localparam int unsigned CW = clog2(depth + 1);

    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          inflight_q;
    logic          err_q, err_d;
    logic          push;
    logic          pop;

    // Slots committed = buffered responses + the one read in flight
    assign used = {1'b0, count} + (CW + 1)'(inflight_q);

    // Credit depends on registered state only; held low during reset
    assign REQ_READY    = RST_N & (used < (CW + 1)'(depth));
    assign BRAM_RD_EN   = REQ_VALID & REQ_READY;
    assign BRAM_RD_ADDR = REQ_ADDR;

    assign push = BRAM_DOUT_RDY & inflight_q;
    assign pop  = RESP_VALID & RESP_READY;

    // Data arriving with nothing outstanding is dropped and flagged
    assign err_d        = err_q | (BRAM_DOUT_RDY & ~inflight_q);
    assign ERR_SPURIOUS = err_q;

    // In-flight marker and sticky error flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= BRAM_RD_EN;
            err_q      <= err_d;
        end
    end

    bram_read_client_resp_fifo #(
        .data_width(data_width),
        .depth     (depth)
    ) u_fifo (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .push_i (push),
        .data_i (BRAM_DOUT),
        .pop_i  (pop),
        .valid_o(RESP_VALID),
        .data_o (RESP_DATA),
        .count_o(count)
    );

    // A read issued last cycle must return data this cycle
    a_dout_rdy: assert property (
        @(posedge CLK) disable iff (!RST_N)
        inflight_q |-> BRAM_DOUT_RDY
    );

endmodule

// File: tb/tb_bram_read_client.sv
// Randomized bench for bram_read_client against a
// request-queue reference model with a BRAM model.
module tb_bram_read_client;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic          REQ_READY;
    logic          BRAM_RD_EN;
    logic [AW-1:0] BRAM_RD_ADDR;
    logic [DW-1:0] BRAM_DOUT;
    logic          BRAM_DOUT_RDY;
    logic          RESP_VALID;
    logic [DW-1:0] RESP_DATA;
    logic          RESP_READY = 1'b0;
    logic          ERR_SPURIOUS;

    always #5 CLK = ~CLK;

    bram_read_client #(
        .addr_width(AW),
        .data_width(DW),
        .depth     (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ_VALID    (REQ_VALID),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_READY    (REQ_READY),
        .BRAM_RD_EN   (BRAM_RD_EN),
        .BRAM_RD_ADDR (BRAM_RD_ADDR),
        .BRAM_DOUT    (BRAM_DOUT),
        .BRAM_DOUT_RDY(BRAM_DOUT_RDY),
        .RESP_VALID   (RESP_VALID),
        .RESP_DATA    (RESP_DATA),
        .RESP_READY   (RESP_READY),
        .ERR_SPURIOUS (ERR_SPURIOUS)
    );

    // BRAM model: one-cycle read latency, plus injectable stray DOUT_RDY
    logic [DW-1:0] mem [256];
    logic          rdy_q  = 1'b0;
    logic [DW-1:0] dout_q = '0;
    logic          inject = 1'b0;

    always @(posedge CLK) begin
        rdy_q  <= BRAM_RD_EN;
        dout_q <= mem[BRAM_RD_ADDR];
    end

    assign BRAM_DOUT_RDY = rdy_q | inject;
    assign BRAM_DOUT     = dout_q;

    // Reference model: accepted requests in order, each visible 2 cycles later
    typedef struct {
        logic [DW-1:0] d;
        int            rc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    bit   err_exp  = 1'b0;
    bit   prev_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [AW-1:0] a,
                        input bit rr, input bit inj);
        bit er;
        bit ev;
        bit acc;
        @(posedge CLK);
        #1;
        REQ_VALID  = v;
        REQ_ADDR   = a;
        RESP_READY = rr;
        inject     = inj;
        #4;
        er  = (q.size() < DEPTH);
        ev  = (q.size() != 0) && (q[0].rc <= cyc);
        acc = v & er;
        chk("req_ready", 32'(REQ_READY), 32'(er));
        chk("rd_en", 32'(BRAM_RD_EN), 32'(acc));
        if (acc) chk("rd_addr", 32'(BRAM_RD_ADDR), 32'(a));
        chk("resp_valid", 32'(RESP_VALID), 32'(ev));
        if (ev) chk("resp_data", 32'(RESP_DATA), 32'(q[0].d));
        chk("err_spurious", 32'(ERR_SPURIOUS), 32'(err_exp));
        if (BRAM_DOUT_RDY && !prev_acc) err_exp = 1'b1;
        if (ev && rr) void'(q.pop_front());
        if (acc) begin
            q.push_back('{d: mem[a], rc: cyc + 2});
            acc_cnt++;
        end
        prev_acc = acc;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[5] = 8'hA5;

        // Reset state, with a request pending
        #2;
        REQ_VALID = 1'b1;
        #1;
        chk("rst_req_ready", 32'(REQ_READY), 32'd0);
        chk("rst_rd_en", 32'(BRAM_RD_EN), 32'd0);
        chk("rst_resp_valid", 32'(RESP_VALID), 32'd0);
        chk("rst_resp_data", 32'(RESP_DATA), 32'd0);
        chk("rst_err", 32'(ERR_SPURIOUS), 32'd0);
        REQ_VALID = 1'b0;
        #19;
        RST_N = 1'b1;

        // Single read: data at accept+2
        step(1'b1, 8'd5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t1_valid", 32'(RESP_VALID), 32'd1);
        chk("t1_data", 32'(RESP_DATA), 32'hA5);
        drain(2);

        // Streaming back-to-back
        a0 = acc_cnt;
        for (int i = 0; i < 16; i++) step(1'b1, AW'(i), 1'b1, 1'b0);
        chk("t2_accepts", 32'(acc_cnt - a0), 32'd16);
        drain(4);

        // Back-pressure fills exactly DEPTH credits
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) step(1'b1, AW'($urandom), 1'b0, 1'b0);
        chk("t3_issued", 32'(acc_cnt - a0), 32'(DEPTH));
        chk("t3_req_ready", 32'(REQ_READY), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, AW'($urandom), 1'b1, 1'b0);
        drain(5);
        chk("t3_empty", 32'(RESP_VALID), 32'd0);

        // Random ops with alternating-ish RESP_READY
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), AW'($urandom),
                 (i % 2 == 0) || ($urandom_range(0, 3) == 0), 1'b0);
        end
        drain(6);

        // Spurious response with nothing outstanding
        chk("t5_err_pre", 32'(ERR_SPURIOUS), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        drain(3);
        chk("t5_err", 32'(ERR_SPURIOUS), 32'd1);
        chk("t5_fifo", 32'(RESP_VALID), 32'd0);

        // Async reset with 2 queued and 1 in flight
        for (int i = 0; i < 3; i++) step(1'b1, AW'($urandom), 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        REQ_VALID  = 1'b1;
        RESP_READY = 1'b0;
        #1;
        chk("t6_pre_valid", 32'(RESP_VALID), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("t6_req_ready", 32'(REQ_READY), 32'd0);
        chk("t6_rd_en", 32'(BRAM_RD_EN), 32'd0);
        chk("t6_resp_valid", 32'(RESP_VALID), 32'd0);
        chk("t6_resp_data", 32'(RESP_DATA), 32'd0);
        chk("t6_err", 32'(ERR_SPURIOUS), 32'd0);
        q.delete();
        err_exp  = 1'b0;
        prev_acc = 1'b0;
        @(posedge CLK);
        #5;
        chk("t6_hold_ready", 32'(REQ_READY), 32'd0);
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        step(1'b1, 8'd5, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_data", 32'(RESP_DATA), 32'hA5);
        chk("t6_err_post", 32'(ERR_SPURIOUS), 32'd1);
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
